// File: rtl/mult_array_pkg.sv
// ---------------------------------------------------------------------------
// mult_array_pkg
//   Shared helpers for the pipelined shift-and-add array multiplier.
//   - cfg_legal      : legality check for the WIDTH / STAGES pair
//   - rows_per_stage : number of adder rows handled by each pipeline stage
//   - row_term       : one partial-product row (extend, shift, negate the
//                      top row in signed mode), computed at MAX_WIDTH and
//                      truncated by the caller to 2*WIDTH bits
// ---------------------------------------------------------------------------
package mult_array_pkg;

    // Widest operand the row helper is sized for.
    localparam int MAX_WIDTH = 32;

    function automatic logic cfg_legal(input int width, input int stages);
        return (width >= 2) && (width <= MAX_WIDTH) &&
               (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    function automatic int rows_per_stage(input int width, input int stages);
        return width / stages;
    endfunction

    // Row term modulo 2^(2*MAX_WIDTH). Bits above 2*width are don't-care for
    // the caller, so filling them with the sign keeps the low part exact.
    function automatic logic [2*MAX_WIDTH-1:0] row_term(
        input logic [MAX_WIDTH-1:0] b,
        input int                   width,
        input int                   row,
        input logic                 a_bit,
        input logic                 mode
    );
        logic [2*MAX_WIDTH-1:0] ext;
        logic                   fill;
        fill = mode & b[width-1];
        ext  = {(2*MAX_WIDTH){fill}};
        for (int j = 0; j < MAX_WIDTH; j++) begin
            if (j < width) begin
                ext[j] = b[j];
            end
        end
        ext = ext << row;
        if (!a_bit) begin
            ext = '0;
        end else if (mode && (row == width - 1)) begin
            // The top multiplier bit carries weight -2^(width-1) in two's complement.
            ext = -ext;
        end
        return ext;
    endfunction

endpackage

// File: rtl/mult_array_stage.sv
// ---------------------------------------------------------------------------
// mult_array_stage
//   One pipeline stage: adds rows (K-1)*R .. K*R-1 onto the incoming partial
//   sum and registers the result together with the forwarded operands.
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     i_valid               upstream rank holds valid data
//     i_psum, i_a, i_b,
//     i_mode                upstream partial sum / operands / signed mode
//     o_in_ready            this rank can load this cycle (empty or advancing)
//     i_out_ready           downstream can take this rank's contents
//     o_valid, o_psum,
//     o_a, o_b, o_mode      this rank's registered contents
// ---------------------------------------------------------------------------
module mult_array_stage
    import mult_array_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int K      = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    input  logic [2*WIDTH-1:0]   i_psum,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic                 i_mode,
    output logic                 o_in_ready,
    input  logic                 i_out_ready,
    output logic                 o_valid,
    output logic [2*WIDTH-1:0]   o_psum,
    output logic [WIDTH-1:0]     o_a,
    output logic [WIDTH-1:0]     o_b,
    output logic                 o_mode
);

    localparam int R         = rows_per_stage(WIDTH, STAGES);
    localparam int FIRST_ROW = (K - 1) * R;

    logic [2*WIDTH-1:0] w_sum;
    logic               r_valid;
    logic [2*WIDTH-1:0] r_psum;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_mode;

    always_comb begin
        w_sum = i_psum;
        for (int i = 0; i < R; i++) begin
            w_sum = w_sum + (2*WIDTH)'(row_term(MAX_WIDTH'(i_b), WIDTH, FIRST_ROW + i,
                                                i_a[FIRST_ROW + i], i_mode));
        end
    end

    // A rank reloads when empty or when its contents leave this cycle.
    assign o_in_ready = !r_valid || i_out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_psum  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_mode  <= 1'b0;
        end else if (o_in_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_psum <= w_sum;
                r_a    <= i_a;
                r_b    <= i_b;
                r_mode <= i_mode;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_psum  = r_psum;
    assign o_a     = r_a;
    assign o_b     = r_b;
    assign o_mode  = r_mode;

endmodule

// File: rtl/multiplier_array_pipe.sv
// ---------------------------------------------------------------------------
// multiplier_array_pipe
//   Pipelined shift-and-add array multiplier, signed/unsigned per operand
//   pair, valid/ready on both sides, STAGES adder-row stages.
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1. in_ready depends only on internal valid bits and out_ready (never
//   on in_valid); y/out_valid hold while out_valid=1 and out_ready=0.
//   Ports:
//     clk, rst_n              clock, async active-low reset
//     in_valid, in_ready      input handshake
//     a, b, signed_mode       multiplier, multiplicand, 1 = two's complement
//     out_valid, out_ready    output handshake
//     y                       2*WIDTH-bit product (straight from last rank)
// ---------------------------------------------------------------------------
module multiplier_array_pipe
    import mult_array_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   y
);

    if (!cfg_legal(WIDTH, STAGES)) begin : g_bad_cfg
        $error("multiplier_array_pipe: WIDTH must be >= 2 and divisible by STAGES");
    end

    // Rank 0: input register.
    logic             r_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_mode;

    // Index k carries rank k's contents; w_down_rdy[k] is "rank k may advance".
    logic               w_valid    [0:STAGES];
    logic [2*WIDTH-1:0] w_psum     [0:STAGES];
    logic [WIDTH-1:0]   w_a        [0:STAGES];
    logic [WIDTH-1:0]   w_b        [0:STAGES];
    logic               w_mode     [0:STAGES];
    logic               w_down_rdy [0:STAGES];

    assign in_ready = !r_valid || w_down_rdy[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_mode  <= 1'b0;
        end else if (in_ready) begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_a    <= a;
                r_b    <= b;
                r_mode <= signed_mode;
            end
        end
    end

    assign w_valid[0] = r_valid;
    assign w_psum[0]  = '0;
    assign w_a[0]     = r_a;
    assign w_b[0]     = r_b;
    assign w_mode[0]  = r_mode;

    assign w_down_rdy[STAGES] = out_ready;

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        mult_array_stage #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES),
            .K      (k)
        ) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_valid     (w_valid[k-1]),
            .i_psum      (w_psum[k-1]),
            .i_a         (w_a[k-1]),
            .i_b         (w_b[k-1]),
            .i_mode      (w_mode[k-1]),
            .o_in_ready  (w_down_rdy[k-1]),
            .i_out_ready (w_down_rdy[k]),
            .o_valid     (w_valid[k]),
            .o_psum      (w_psum[k]),
            .o_a         (w_a[k]),
            .o_b         (w_b[k]),
            .o_mode      (w_mode[k])
        );
    end

    // Operands forwarded out of the last rank have no consumer.
    logic w_unused_tail;
    assign w_unused_tail = ^{w_a[STAGES], w_b[STAGES], w_mode[STAGES]};

    assign out_valid = w_valid[STAGES];
    assign y         = w_psum[STAGES];

endmodule

// File: tb/tb_multiplier_array_pipe.sv
module tb_multiplier_array_pipe;

    logic clk;
    logic rst_n;

    // 8-bit, 2-stage instance
    logic        in_valid8, in_ready8, mode8, out_valid8, out_ready8;
    logic [7:0]  a8, b8;
    logic [15:0] y8;

    // 16-bit, 4-stage instance
    logic        in_valid16, in_ready16, mode16, out_valid16, out_ready16;
    logic [15:0] a16, b16;
    logic [31:0] y16;

    int total;
    int bad;

    multiplier_array_pipe #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid8),
        .in_ready    (in_ready8),
        .a           (a8),
        .b           (b8),
        .signed_mode (mode8),
        .out_valid   (out_valid8),
        .out_ready   (out_ready8),
        .y           (y8)
    );

    multiplier_array_pipe #(.WIDTH(16), .STAGES(4)) dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid16),
        .in_ready    (in_ready16),
        .a           (a16),
        .b           (b16),
        .signed_mode (mode16),
        .out_valid   (out_valid16),
        .out_ready   (out_ready16),
        .y           (y16)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        in_valid8 = 0; a8 = 0; b8 = 0; mode8 = 0; out_ready8 = 1;
        in_valid16 = 0; a16 = 0; b16 = 0; mode16 = 0; out_ready16 = 1;
        #3;
        repeat (2) tick();
        total++;
        if (out_valid8 !== 1'b0 || y8 !== 16'h0 || in_ready8 !== 1'b1) begin
            bad++;
            $display("FAIL reset8: out_valid=%b y=%h in_ready=%b, want 0 0000 1", out_valid8, y8, in_ready8);
        end
        total++;
        if (out_valid16 !== 1'b0 || y16 !== 32'h0 || in_ready16 !== 1'b1) begin
            bad++;
            $display("FAIL reset16: out_valid=%b y=%h in_ready=%b, want 0 0 1", out_valid16, y16, in_ready16);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_unsigned_max();
        a8 = 8'd255; b8 = 8'd255; mode8 = 0; in_valid8 = 1; out_ready8 = 1;
        total++;
        if (in_ready8 !== 1'b1) begin
            bad++;
            $display("FAIL umax_in_ready: got %b want 1", in_ready8);
        end
        tick();                       // accepted here (edge t)
        in_valid8 = 0;
        total++;
        if (out_valid8 !== 1'b0) begin
            bad++;
            $display("FAIL umax_lat_t0: out_valid=%b want 0", out_valid8);
        end
        tick();                       // edge t+1
        total++;
        if (out_valid8 !== 1'b0) begin
            bad++;
            $display("FAIL umax_lat_t1: out_valid=%b want 0", out_valid8);
        end
        tick();                       // edge t+2
        total++;
        if (out_valid8 !== 1'b1 || y8 !== 16'hFE01) begin
            bad++;
            $display("FAIL umax_result: out_valid=%b y=%h want 1 fe01", out_valid8, y8);
        end
        tick();
        total++;
        if (out_valid8 !== 1'b0) begin
            bad++;
            $display("FAIL umax_single: out_valid=%b want 0", out_valid8);
        end
    endtask

    task automatic test_signed_mix();
        logic [7:0]  va [3];
        logic [7:0]  vb [3];
        logic        vm [3];
        logic [15:0] ve [3];
        int sent, got;
        va = '{8'h80, 8'hFF, 8'hFF};
        vb = '{8'h80, 8'h05, 8'h05};
        vm = '{1'b1, 1'b1, 1'b0};
        ve = '{16'h4000, 16'hFFFB, 16'h04FB};
        sent = 0; got = 0;
        out_ready8 = 1;
        for (int c = 0; c < 8; c++) begin
            if (out_valid8) begin
                total++;
                if (got >= 3) begin
                    bad++;
                    $display("FAIL signed_extra: unexpected y=%h", y8);
                end else if (y8 !== ve[got]) begin
                    bad++;
                    $display("FAIL signed_y%0d: got %h want %h", got, y8, ve[got]);
                end
                got++;
            end
            if (sent < 3) begin
                a8 = va[sent]; b8 = vb[sent]; mode8 = vm[sent]; in_valid8 = 1;
            end else begin
                in_valid8 = 0;
            end
            if (in_valid8 && in_ready8) sent++;
            tick();
        end
        in_valid8 = 0;
        total++;
        if (got != 3) begin
            bad++;
            $display("FAIL signed_count: got %0d products want 3", got);
        end
    endtask

    task automatic test_stream();
        logic [7:0]  va [4];
        logic [7:0]  vb [4];
        logic [15:0] ve [4];
        int sent, got, first_c;
        va = '{8'd3, 8'd10, 8'd0, 8'd1};
        vb = '{8'd4, 8'd10, 8'd200, 8'd255};
        ve = '{16'd12, 16'd100, 16'd0, 16'd255};
        sent = 0; got = 0; first_c = -1;
        out_ready8 = 1; mode8 = 0;
        for (int c = 0; c < 9; c++) begin
            if (out_valid8) begin
                if (first_c < 0) first_c = c;
                total++;
                if (got >= 4 || y8 !== ve[got] || c != first_c + got) begin
                    bad++;
                    $display("FAIL stream_y%0d: got %h at cycle %0d want %h at cycle %0d",
                             got, y8, c, (got < 4) ? ve[got] : 16'hxxxx, first_c + got);
                end
                got++;
            end
            if (sent < 4) begin
                a8 = va[sent]; b8 = vb[sent]; in_valid8 = 1;
                total++;
                if (in_ready8 !== 1'b1) begin
                    bad++;
                    $display("FAIL stream_in_ready: got %b want 1", in_ready8);
                end
            end else begin
                in_valid8 = 0;
            end
            if (in_valid8 && in_ready8) sent++;
            tick();
        end
        in_valid8 = 0;
        total++;
        if (got != 4) begin
            bad++;
            $display("FAIL stream_count: got %0d want 4", got);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  va [4];
        logic [7:0]  vb [4];
        logic [15:0] exp_q[$];
        logic [15:0] exp_v;
        int sent, got;
        va = '{8'd2, 8'd4, 8'd6, 8'd8};
        vb = '{8'd3, 8'd5, 8'd7, 8'd9};
        sent = 0; got = 0;
        mode8 = 0; out_ready8 = 0;
        for (int c = 0; c < 6; c++) begin
            a8 = va[sent]; b8 = vb[sent]; in_valid8 = 1;
            if (in_ready8) begin
                exp_q.push_back(16'(va[sent] * vb[sent]));
                sent++;
            end
            tick();
        end
        total++;
        if (sent != 3 || in_ready8 !== 1'b0) begin
            bad++;
            $display("FAIL bp_fill: accepts=%0d in_ready=%b want 3 0", sent, in_ready8);
        end
        for (int c = 0; c < 3; c++) begin
            total++;
            if (out_valid8 !== 1'b1 || y8 !== 16'd6 || in_ready8 !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold: out_valid=%b y=%h in_ready=%b want 1 0006 0", out_valid8, y8, in_ready8);
            end
            tick();
        end
        // Full pipe: raising out_ready must open the input in the same cycle.
        out_ready8 = 1;
        #1;
        total++;
        if (in_ready8 !== 1'b1) begin
            bad++;
            $display("FAIL bp_release_ready: got %b want 1", in_ready8);
        end
        for (int c = 0; c < 10; c++) begin
            if (out_valid8) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL bp_extra: unexpected y=%h", y8);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (y8 !== exp_v) begin
                        bad++;
                        $display("FAIL bp_order%0d: got %h want %h", got, y8, exp_v);
                    end
                end
                got++;
            end
            if (sent < 4) begin
                a8 = va[sent]; b8 = vb[sent]; in_valid8 = 1;
            end else begin
                in_valid8 = 0;
            end
            if (in_valid8 && in_ready8) begin
                exp_q.push_back(16'(va[sent] * vb[sent]));
                sent++;
            end
            tick();
        end
        in_valid8 = 0;
        total++;
        if (got != 4 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL bp_count: got %0d products, %0d missing, want 4 0", got, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int got;
        got = 0;
        out_ready8 = 1; mode8 = 0;
        a8 = 8'd3; b8 = 8'd3; in_valid8 = 1;
        tick();
        a8 = 8'd5; b8 = 8'd5;
        tick();
        in_valid8 = 0;
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid8 !== 1'b0 || y8 !== 16'h0 || in_ready8 !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_async: out_valid=%b y=%h in_ready=%b want 0 0000 1", out_valid8, y8, in_ready8);
        end
        tick();
        rst_n = 1'b1;
        tick();
        a8 = 8'd7; b8 = 8'd6; in_valid8 = 1;
        tick();
        in_valid8 = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid8) begin
                total++;
                if (y8 !== 16'd42 || got != 0) begin
                    bad++;
                    $display("FAIL rstmid_fresh: got %h (#%0d) want 002a once", y8, got);
                end
                got++;
            end
            tick();
        end
        total++;
        if (got != 1) begin
            bad++;
            $display("FAIL rstmid_count: got %0d products want 1", got);
        end
    endtask

    task automatic test_random16();
        logic [31:0] exp_q[$];
        int          exp_t[$];
        logic [31:0] exp_v;
        logic signed [31:0] sa, sb;
        int sent, cyc, t;
        sent = 0; cyc = 0;
        out_ready16 = 1;
        while ((sent < 1000 || exp_q.size() != 0) && cyc < 3000) begin
            if (out_valid16) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rand_extra: unexpected y=%h", y16);
                end else begin
                    exp_v = exp_q.pop_front();
                    t = exp_t.pop_front();
                    if (y16 !== exp_v || (cyc - t) != 4) begin
                        bad++;
                        $display("FAIL rand_y: got %h latency %0d want %h latency 4", y16, cyc - t, exp_v);
                    end
                end
            end
            if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                a16 = 16'($urandom_range(0, 65535));
                b16 = 16'($urandom_range(0, 65535));
                mode16 = 1'($urandom_range(0, 1));
                in_valid16 = 1;
            end else begin
                in_valid16 = 0;
            end
            if (in_valid16 && in_ready16) begin
                if (mode16) begin
                    sa = {{16{a16[15]}}, a16};
                    sb = {{16{b16[15]}}, b16};
                    exp_q.push_back(32'(sa * sb));
                end else begin
                    exp_q.push_back({16'h0, a16} * {16'h0, b16});
                end
                exp_t.push_back(cyc + 1);
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid16 = 0;
        total++;
        if (sent != 1000 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL rand_drain: sent=%0d outstanding=%0d want 1000 0", sent, exp_q.size());
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_unsigned_max();
        test_signed_mix();
        test_stream();
        test_backpressure();
        test_reset_mid();
        test_random16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiplier_array_pipe.md
# multiplier_array_pipe

Parametrised, pipelined shift-and-add array multiplier with valid/ready handshakes on both sides, selectable signed/unsigned operation and a configurable number of pipeline stages. It is the general-purpose successor to the fixed 8-bit, two-stage array multiplier. Datapath blocks that need a full-precision product at one result per cycle instantiate it, and it tolerates downstream stalls.

## Interface
- `WIDTH`, 8: operand width in bits; must be ≥ 2.
- `STAGES`, 2: number of adder-row pipeline stages; must divide `WIDTH` (elaboration error otherwise).
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `in_valid`  in  1: operands `a`, `b` and `signed_mode` are valid.
- `in_ready`  out  1: block accepts operands this cycle.
- `a`  in  `WIDTH`: multiplier operand (selects rows).
- `b`  in  `WIDTH`: multiplicand operand (shifted rows).
- `signed_mode`  in  1: 1 = two's-complement operands, 0 = unsigned.
- `out_valid`  out  1: `y` holds a completed product.
- `out_ready`  in  1: consumer takes `y` this cycle.
- `y`  out  `2*WIDTH`: product.

## Operation
- Register ranks:
  - Rank 0 is the input register. It holds `a`, `b`, the mode bit and a valid bit.
  - Ranks 1..`STAGES` are stage registers. Each holds the partial sum (`2*WIDTH` bits), the forwarded `a`, `b` and mode, and a valid bit.
  - Rank `STAGES` drives `y` and `out_valid` directly, with no output logic.
- Stage k (1..`STAGES`) adds rows i = (k-1)·R … k·R-1, with R = `WIDTH`/`STAGES`, onto the partial sum from rank k-1. Rank 0 contributes a partial sum of 0.
- Row i term:
  - If `a[i]` = 0, the term is 0.
  - If `a[i]` = 1, the term is `b`, extended to `2*WIDTH` bits (sign-extended if mode = 1, zero-extended otherwise), shifted left by i.
- Signed mode: row `WIDTH`-1 is subtracted instead of added. Unsigned mode adds all rows.
- All arithmetic is modulo 2^(2·`WIDTH`). The result is exact for both modes with no overflow.
- The mode bit is captured with its operands and travels with them. Mixed-mode streams are legal.
- Each rank is loaded when it is empty or when its own contents advance this cycle. Bubbles collapse.
  - Rank `STAGES` advances when `out_ready` = 1.
  - `in_ready` is asserted when rank 0 is empty or is advancing. It is combinational from the valid bits and `out_ready`; there is no combinational path from `in_valid`.
- A transfer occurs when valid and ready are both 1. Products leave in acceptance order and none is dropped or duplicated.

## Timing
- Reset (`rst_n` = 0, asynchronous): all valid bits clear, all data registers clear to 0.
  - Outputs during reset: `out_valid` = 0, `y` = 0, `in_ready` = 1.
  - Operands in flight when reset asserts are discarded.
- Latency: operands accepted at edge t appear at `y` with `out_valid` = 1 after edge t+`STAGES`, provided no stall occurs.
- Throughput: one product per cycle while `out_ready` = 1.
- Stall: while `out_valid` = 1 and `out_ready` = 0, `y` and `out_valid` hold stable.
  - Upstream ranks continue to fill bubbles.
  - `in_ready` drops only when all `STAGES`+1 ranks are full.
- Simultaneous events: when the pipe is full and `out_ready` rises, a new operand is accepted in the same cycle that the oldest product leaves.
- `in_valid` = 1 with `in_ready` = 0 causes no capture. The source must hold its operands.

## Structure
- Shared package `mult_array_pkg` holds:
  - the legality check function for `WIDTH`/`STAGES`;
  - the function computing R;
  - the row-term function (extend, shift, negate-if-last-row-signed).
- Sub-module `mult_array_stage` implements one pipeline stage. It takes the stage index as a parameter and contains the combinational adder rows plus its register rank with valid/advance logic. It is instantiated `STAGES` times in a generate loop.
- Rank 0 and the handshake glue live in the top level.

## Test plan
- `WIDTH`=8, `STAGES`=2, unsigned: a=255, b=255 -> y=0xFE01, with `out_valid` rising exactly 2 edges after acceptance.
- Signed mode:
  - a=0x80, b=0x80 -> y=0x4000;
  - a=0xFF, b=0x05 -> y=0xFFFB;
  - then unsigned a=0xFF, b=0x05 -> y=0x04FB, issued back-to-back.
- Stream of 4 unsigned pairs, (3,4), (10,10), (0,200), (1,255), with `out_ready`=1 -> y = 12, 100, 0, 255 on 4 consecutive cycles, `in_ready` held at 1.
- Backpressure:
  - Hold `out_ready`=0 while streaming -> `in_ready` drops after exactly 3 accepts and `y` stays stable.
  - Release `out_ready` -> all products emerge in order and nothing is lost.
- Reset mid-flight: assert `rst_n`=0 with 2 products in flight -> `out_valid`=0 and `y`=0 immediately. After release, a fresh input a=7, b=6 yields y=42.
- `WIDTH`=16, `STAGES`=4: 1000 random signed and unsigned pairs compared against a reference model, with latency 4 checked.
